// File: rtl/move_sequencer.sv
// Single-axis-at-a-time stepper sequencer: takes one face move, enables that face's driver,
// emits the step pulse train, then holds torque until the external settle timer expires.
module move_sequencer #(
    parameter int STEPS_PER_QUARTER = 50,
    parameter int STEP_PERIOD       = 25000,
    parameter int STEP_HIGH         = 12500,
    parameter int DIR_SETUP         = 25
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        move_valid,
    input  logic [2:0]  move_face,
    input  logic        move_dir,
    input  logic [1:0]  move_turns,
    output logic        move_ready,
    output logic        busy,
    output logic [5:0]  step,
    output logic [5:0]  dir,
    output logic [5:0]  motor_en,
    output logic        delay_start,
    input  logic        delay_done,
    output logic        move_error,
    output logic [15:0] moves_done,
    output logic [2:0]  dbg_state
);

    localparam int CNT_MAX = (STEP_PERIOD > DIR_SETUP) ? STEP_PERIOD : DIR_SETUP;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam int SW      = $clog2(2 * STEPS_PER_QUARTER + 1);

    localparam logic [CW-1:0] SETUP_LAST = CW'(DIR_SETUP - 1);
    localparam logic [CW-1:0] HI_LAST    = CW'(STEP_HIGH - 1);
    localparam logic [CW-1:0] LO_LAST    = CW'(STEP_PERIOD - STEP_HIGH - 1);
    localparam logic [SW-1:0] STEPS_ONE  = SW'(STEPS_PER_QUARTER);
    localparam logic [SW-1:0] STEPS_TWO  = SW'(2 * STEPS_PER_QUARTER);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        STEP_HI,
        STEP_LO,
        SETTLE_START,
        SETTLE_WAIT
    } state_t;

    // Handshake: a move transfers on any cycle where move_valid && move_ready; move_ready is
    // high only in IDLE and the source must hold the move stable until then.
    state_t        state;
    logic [CW-1:0] cnt;
    logic [SW-1:0] steps_left;
    logic [5:0]    face_mask;

    logic          move_bad;
    logic [5:0]    new_mask;
    logic          new_dir;

    assign move_bad  = (move_face > 3'd5) || (move_turns == 2'd0);
    assign new_mask  = 6'b000001 << move_face;
    // Three quarter turns one way is one quarter turn the other way.
    assign new_dir   = (move_turns == 2'd3) ? ~move_dir : move_dir;
    assign dbg_state = state;

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            steps_left  <= '0;
            face_mask   <= '0;
            step        <= '0;
            dir         <= '0;
            motor_en    <= '0;
            delay_start <= 1'b0;
            move_error  <= 1'b0;
            busy        <= 1'b0;
            move_ready  <= 1'b1;
            moves_done  <= '0;
        end else begin
            move_error  <= 1'b0;
            delay_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (move_valid) begin
                        if (move_bad) begin
                            move_error <= 1'b1;
                        end else begin
                            face_mask  <= new_mask;
                            motor_en   <= new_mask;
                            dir        <= new_dir ? new_mask : 6'd0;
                            steps_left <= (move_turns == 2'd2) ? STEPS_TWO : STEPS_ONE;
                            cnt        <= SETUP_LAST;
                            busy       <= 1'b1;
                            move_ready <= 1'b0;
                            state      <= SETUP;
                        end
                    end
                end
                SETUP: begin
                    if (cnt == '0) begin
                        step  <= face_mask;
                        cnt   <= HI_LAST;
                        state <= STEP_HI;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                STEP_HI: begin
                    if (cnt == '0) begin
                        step       <= '0;
                        cnt        <= LO_LAST;
                        steps_left <= steps_left - SW'(1);
                        state      <= STEP_LO;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                STEP_LO: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CW'(1);
                    end else if (steps_left == '0) begin
                        delay_start <= 1'b1;
                        state       <= SETTLE_START;
                    end else begin
                        step  <= face_mask;
                        cnt   <= HI_LAST;
                        state <= STEP_HI;
                    end
                end
                SETTLE_START: begin
                    state <= SETTLE_WAIT;
                end
                SETTLE_WAIT: begin
                    // Driver stays enabled here so the face holds position while settling.
                    if (delay_done) begin
                        moves_done <= moves_done + 16'd1;
                        motor_en   <= '0;
                        dir        <= '0;
                        busy       <= 1'b0;
                        move_ready <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_move_sequencer.sv
// Bench for move_sequencer with small timing parameters: table vectors, reset corner cases
// and randomized moves compared cycle by cycle against a waveform model built from the rules.
module tb_move_sequencer;

    localparam int SPQ = 2;
    localparam int P   = 4;
    localparam int H   = 2;
    localparam int DS  = 1;

    logic        clock = 1'b0;
    logic        reset;
    logic        move_valid;
    logic [2:0]  move_face;
    logic        move_dir;
    logic [1:0]  move_turns;
    logic        move_ready;
    logic        busy;
    logic [5:0]  step;
    logic [5:0]  dir;
    logic [5:0]  motor_en;
    logic        delay_start;
    logic        delay_done;
    logic        move_error;
    logic [15:0] moves_done;
    logic [2:0]  dbg_state;

    move_sequencer #(
        .STEPS_PER_QUARTER(SPQ),
        .STEP_PERIOD(P),
        .STEP_HIGH(H),
        .DIR_SETUP(DS)
    ) dut (
        .clock(clock),
        .reset(reset),
        .move_valid(move_valid),
        .move_face(move_face),
        .move_dir(move_dir),
        .move_turns(move_turns),
        .move_ready(move_ready),
        .busy(busy),
        .step(step),
        .dir(dir),
        .motor_en(motor_en),
        .delay_start(delay_start),
        .delay_done(delay_done),
        .move_error(move_error),
        .moves_done(moves_done),
        .dbg_state(dbg_state)
    );

    always #5 clock = ~clock;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          exp_moves = 0;
    logic [21:0] exp_q[$];

    typedef struct {
        logic [2:0] face;
        logic       dir;
        logic [1:0] turns;
        logic       err;
        int         pulses;
        logic       dirbit;
    } vec_t;

    vec_t tbl[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    function automatic logic [21:0] mk(input logic [5:0] s, input logic [5:0] dv,
                                       input logic [5:0] en, input logic ds, input logic b,
                                       input logic r, input logic e);
        return {s, dv, en, ds, b, r, e};
    endfunction

    function automatic logic [21:0] pack();
        return {step, dir, motor_en, delay_start, busy, move_ready, move_error};
    endfunction

    // Reference rules for a single move request.
    task automatic ref_move(input logic [2:0] f, input logic d, input logic [1:0] tr,
                            output logic err, output int pulses, output logic dbit);
        err    = (f > 3'd5) || (tr == 2'd0);
        pulses = err ? 0 : ((tr == 2'd2) ? 2 : 1) * SPQ;
        dbit   = (tr == 2'd3) ? ~d : d;
    endtask

    task automatic do_move(input logic [2:0] f, input logic d, input logic [1:0] tr,
                           input logic e_err, input int pulses, input logic dbit,
                           input int w, input bit noise);
        logic [5:0]  m;
        logic [5:0]  dm;
        logic [21:0] got;
        logic [21:0] expv;
        int          t;
        int          done_at;
        int          rises;
        logic        prev;
        m  = e_err ? 6'd0 : (6'b000001 << f);
        dm = dbit ? m : 6'd0;
        check("ready_before", {31'd0, move_ready}, 32'd1);
        move_valid = 1'b1;
        move_face  = f;
        move_dir   = d;
        move_turns = tr;
        @(negedge clock);
        move_valid = 1'b0;
        exp_q.delete();
        done_at = -1;
        if (e_err) begin
            exp_q.push_back(mk(6'd0, 6'd0, 6'd0, 1'b0, 1'b0, 1'b1, 1'b1));
            exp_q.push_back(mk(6'd0, 6'd0, 6'd0, 1'b0, 1'b0, 1'b1, 1'b0));
        end else begin
            for (int i = 0; i < DS; i++) exp_q.push_back(mk(6'd0, dm, m, 1'b0, 1'b1, 1'b0, 1'b0));
            for (int i = 0; i < pulses * P; i++)
                exp_q.push_back(mk(((i % P) < H) ? m : 6'd0, dm, m, 1'b0, 1'b1, 1'b0, 1'b0));
            exp_q.push_back(mk(6'd0, dm, m, 1'b1, 1'b1, 1'b0, 1'b0));
            for (int i = 0; i <= w; i++) exp_q.push_back(mk(6'd0, dm, m, 1'b0, 1'b1, 1'b0, 1'b0));
            exp_q.push_back(mk(6'd0, 6'd0, 6'd0, 1'b0, 1'b0, 1'b1, 1'b0));
            done_at = DS + pulses * P + 1 + w;
        end
        t = 0;
        rises = 0;
        prev = 1'b0;
        while (exp_q.size() > 0) begin
            got  = pack();
            expv = exp_q.pop_front();
            check("trace", {10'd0, got}, {10'd0, expv});
            if (((step & m) != 6'd0) && !prev) rises++;
            prev = ((step & m) != 6'd0);
            delay_done = 1'b0;
            if (!e_err) begin
                if (t == done_at || t == DS) delay_done = 1'b1;
                else if (noise && t <= DS + pulses * P) delay_done = 1'($urandom_range(0, 1));
            end
            if (noise && !e_err && t < done_at) begin
                move_valid = 1'($urandom_range(0, 1));
                move_face  = 3'($urandom_range(0, 7));
                move_dir   = 1'($urandom_range(0, 1));
                move_turns = 2'($urandom_range(0, 3));
            end else begin
                move_valid = 1'b0;
            end
            @(negedge clock);
            t++;
        end
        delay_done = 1'b0;
        move_valid = 1'b0;
        if (!e_err) begin
            check("pulses", rises, pulses);
            exp_moves++;
        end
        check("moves_done", {16'd0, moves_done}, exp_moves);
    endtask

    initial begin
        logic [2:0] rf;
        logic       rd;
        logic [1:0] rt;
        logic       re;
        int         rp;
        logic       rb;

        tbl[0] = '{face: 3'd3, dir: 1'b1, turns: 2'd1, err: 1'b0, pulses: 2, dirbit: 1'b1};
        tbl[1] = '{face: 3'd0, dir: 1'b0, turns: 2'd2, err: 1'b0, pulses: 4, dirbit: 1'b0};
        tbl[2] = '{face: 3'd5, dir: 1'b1, turns: 2'd3, err: 1'b0, pulses: 2, dirbit: 1'b0};
        tbl[3] = '{face: 3'd6, dir: 1'b0, turns: 2'd1, err: 1'b1, pulses: 0, dirbit: 1'b0};
        tbl[4] = '{face: 3'd2, dir: 1'b1, turns: 2'd0, err: 1'b1, pulses: 0, dirbit: 1'b0};
        tbl[5] = '{face: 3'd7, dir: 1'b1, turns: 2'd2, err: 1'b1, pulses: 0, dirbit: 1'b0};
        tbl[6] = '{face: 3'd1, dir: 1'b0, turns: 2'd3, err: 1'b0, pulses: 2, dirbit: 1'b1};
        tbl[7] = '{face: 3'd4, dir: 1'b1, turns: 2'd2, err: 1'b0, pulses: 4, dirbit: 1'b1};

        reset      = 1'b1;
        move_valid = 1'b0;
        move_face  = 3'd0;
        move_dir   = 1'b0;
        move_turns = 2'd0;
        delay_done = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check("reset_idle", {10'd0, pack()}, {10'd0, mk(6'd0, 6'd0, 6'd0, 1'b0, 1'b0, 1'b1, 1'b0)});
        check("reset_moves", {16'd0, moves_done}, 32'd0);

        for (int i = 0; i < 8; i++)
            do_move(tbl[i].face, tbl[i].dir, tbl[i].turns, tbl[i].err, tbl[i].pulses,
                    tbl[i].dirbit, (i == 0) ? 10 : 2, 1'b0);

        // Reset landing in the middle of a step-high phase, with a move offered during reset.
        move_valid = 1'b1;
        move_face  = 3'd2;
        move_dir   = 1'b1;
        move_turns = 2'd1;
        @(negedge clock);
        move_valid = 1'b0;
        repeat (DS) @(negedge clock);
        check("step_hi_pre_reset", {26'd0, step}, 32'h4);
        reset      = 1'b1;
        move_valid = 1'b1;
        @(negedge clock);
        check("reset_mid_step", {11'd0, pack() & 22'h3FFFFD}, 32'd0);
        check("reset_mid_moves", {16'd0, moves_done}, 32'd0);
        @(negedge clock);
        check("reset_hold_no_start", {11'd0, pack() & 22'h3FFFFD}, 32'd0);
        reset      = 1'b0;
        move_valid = 1'b0;
        exp_moves  = 0;
        @(negedge clock);
        check("ready_after_reset", {10'd0, pack()}, {10'd0, mk(6'd0, 6'd0, 6'd0, 1'b0, 1'b0, 1'b1, 1'b0)});

        for (int i = 0; i < 25; i++) begin
            rf = 3'($urandom_range(0, 7));
            rd = 1'($urandom_range(0, 1));
            rt = 2'($urandom_range(0, 3));
            ref_move(rf, rd, rt, re, rp, rb);
            do_move(rf, rd, rt, re, rp, rb, $urandom_range(0, 6), 1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
